alarm_bank: RTL and testbench
=============================

// Module: alarm_bank
// PURPOSE
//  Parametrised multi-alarm engine; next generation of the single-alarm logic in clock_controller.
//  Holds NUM_ALARMS independent alarm slots, compares them against the live time from time_counter,
//  arbitrates ringing, and supports snooze and auto-timeout.
//  Sits between time_counter and buzzer_controller; alarm_on drives buzzer_controller.alarm_on.
// PARAMETERS
//  NUM_ALARMS      4   number of alarm slots (1..8)
//  SNOOZE_MIN      5   snooze length in minutes (1..59)
//  RING_TIMEOUT_S  60  seconds of ringing before automatic stop (1..255)
//  IDX_W           $clog2(NUM_ALARMS) (min 1)   slot index width; localparam
// PORTS
//  clk           in   1      system clock, single clock domain
//  rst           in   1      synchronous, active-high reset
//  sec_tick      in   1      1-cycle 1 Hz enable, same signal fed to time_counter.clk_1hz_en
//  hour_in       in   5      current hour 0..23, from time_counter
//  min_in        in   6      current minute 0..59
//  sec_in        in   6      current second 0..59
//  wr_en         in   1      1-cycle write strobe for slot wr_idx
//  wr_idx        in   IDX_W  slot to write / read
//  wr_hour       in   5      alarm hour to store
//  wr_min        in   6      alarm minute to store
//  wr_enable     in   1      slot enable bit to store
//  snooze_pulse  in   1      debounced 1-cycle key pulse: snooze current ringer
//  off_pulse     in   1      debounced 1-cycle key pulse: stop current ringer
//  rd_hour       out  5      stored hour of slot wr_idx (combinational read)
//  rd_min        out  6      stored minute of slot wr_idx
//  enabled_mask  out  N      per-slot enable bits
//  snoozed_mask  out  N      per-slot SNOOZED state
//  alarm_on      out  1      registered: some slot is RINGING
//  ring_idx      out  IDX_W  slot currently ringing (valid when alarm_on)
//  wr_err        out  1      registered 1-cycle pulse: write rejected
// BEHAVIOUR
//  Reset: all slots hour=0,min=0,enable=0,state IDLE; pending=0; all outputs 0.
//  Per-slot FSM: IDLE -> PENDING -> RINGING -> {IDLE | SNOOZED}; SNOOZED -> PENDING.
//  Match: tick_d = sec_tick delayed 1 cycle (counter has updated). On tick_d with sec_in==0,
//   enable=1, hour/min equal, slot state IDLE -> PENDING. Fires once per day per slot.
//  Arbiter: if no slot RINGING, lowest-index PENDING slot -> RINGING, ring counter cleared.
//   alarm_on/ring_idx registered: alarm_on rises 2 clk after the match cycle (3 after sec_tick).
//   Other matches during ringing stay PENDING and ring in index order afterwards.
//  Ring counter: increments on sec_tick while RINGING; at RING_TIMEOUT_S -> IDLE (no snooze).
//  off_pulse while RINGING -> IDLE; enable stays 1 (re-arms next day). Ignored if nothing rings.
//  snooze_pulse while RINGING -> SNOOZED, countdown = SNOOZE_MIN*60, decremented on sec_tick;
//   at 0 -> PENDING. Snooze independent of stored alarm time.
//  off_pulse and snooze_pulse same cycle: off wins.
//  Timeout and key pulse same cycle: key wins.
//  Write: accepted when wr_hour<=23 and wr_min<=59; else no change, wr_err=1 next cycle.
//   Accepted write forces that slot to IDLE (cancels PENDING/RINGING/SNOOZED) and updates fields.
//   Write with wr_enable=0 to a ringing slot drops alarm_on next cycle; next PENDING is then granted.
//  Write and match to the same slot in one cycle: write wins, no match that minute.
//  Time load (user sets clock) is not special-cased; a jump onto hh:mm:00 fires normally.
//  rst mid-ring: alarm_on=0 next cycle; all configuration lost.
//  Arithmetic: snooze countdown 12 bits (max 3540), ring counter 8 bits, no wrap possible.
// STRUCTURE
//  Shared package clock_pkg: HOUR_W=5, MIN_W=6, SEC_W=6, MAX_HOUR=23, MAX_MIN=59,
//   slot state encoding (IDLE, PENDING, RINGING, SNOOZED).
//  Sub-module alarm_slot: one slot's storage, FSM, snooze countdown; generated NUM_ALARMS times.
//  Top holds tick_d, fixed-priority arbiter, ring counter, output registers.
// TESTING
//  Slot0=07:30 en; drive time 07:29:59 -> tick -> 07:30:00 => alarm_on=1, ring_idx=0, 3 clk after tick.
//  Ringing slot0, off_pulse => alarm_on=0 next clk; enabled_mask[0]=1; next 07:30:00 rings again.
//  Ringing, snooze_pulse (SNOOZE_MIN=1) => snoozed_mask[0]=1; alarm_on again after exactly 60 ticks.
//  Slots 1 and 2 both 08:00 => ring_idx=1 first; off_pulse => ring_idx=2 2 clk later.
//  No key, RING_TIMEOUT_S=60 => alarm_on drops after 60th tick; slot IDLE, not snoozed.
//  wr_hour=24 or wr_min=60 => wr_err pulse, rd_hour/rd_min unchanged; valid write to ringer cancels it.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clock/alarm definitions: field widths, legal time limits and alarm slot states.
package clock_pkg;

    localparam int unsigned HOUR_W     = 5;
    localparam int unsigned MIN_W      = 6;
    localparam int unsigned SEC_W      = 6;
    localparam int unsigned SNOOZE_W   = 12;
    localparam int unsigned RING_CNT_W = 8;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

    typedef enum logic [1:0] {
        SlotIdle,
        SlotPending,
        SlotRinging,
        SlotSnoozed
    } slot_state_e;

    // True when hh:mm is a legal time of day.
    function automatic logic valid_time(input logic [HOUR_W-1:0] hour,
                                        input logic [MIN_W-1:0]  min);
        return (hour <= MAX_HOUR) && (min <= MAX_MIN);
    endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: stored hh:mm and enable, lifecycle FSM and snooze countdown.
module alarm_slot
    import clock_pkg::*;
#(
    parameter int unsigned SnoozeMin = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sec_tick_i,
    input  logic              match_tick_i,  // delayed tick landing on second 0
    input  logic [HOUR_W-1:0] hour_i,
    input  logic [MIN_W-1:0]  min_i,
    input  logic              wr_i,          // accepted write addressed to this slot
    input  logic [HOUR_W-1:0] wr_hour_i,
    input  logic [MIN_W-1:0]  wr_min_i,
    input  logic              wr_enable_i,
    input  logic              grant_i,
    input  logic              off_i,
    input  logic              snooze_i,
    input  logic              timeout_i,
    output logic [HOUR_W-1:0] hour_o,
    output logic [MIN_W-1:0]  min_o,
    output logic              enable_o,
    output slot_state_e       state_o,
    output slot_state_e       state_next_o
);

    localparam logic [SNOOZE_W-1:0] SnoozeLoad = SNOOZE_W'(SnoozeMin * 60);
    localparam logic [SNOOZE_W-1:0] SnoozeOne  = SNOOZE_W'(1);

    logic [HOUR_W-1:0]   hour_q, hour_d;
    logic [MIN_W-1:0]    min_q, min_d;
    logic                en_q, en_d;
    slot_state_e         state_q, state_d;
    logic [SNOOZE_W-1:0] snooze_q, snooze_d;

    // Next-state: a write overrides everything; key pulses only act on the ringing slot,
    // with off beating snooze and either beating the timeout.
    always_comb begin
        hour_d   = hour_q;
        min_d    = min_q;
        en_d     = en_q;
        state_d  = state_q;
        snooze_d = snooze_q;
        if (wr_i) begin
            hour_d   = wr_hour_i;
            min_d    = wr_min_i;
            en_d     = wr_enable_i;
            state_d  = SlotIdle;
            snooze_d = '0;
        end else begin
            unique case (state_q)
                SlotIdle: begin
                    if (match_tick_i && en_q && (hour_q == hour_i) && (min_q == min_i)) begin
                        state_d = SlotPending;
                    end
                end
                SlotPending: begin
                    if (grant_i) begin
                        state_d = SlotRinging;
                    end
                end
                SlotRinging: begin
                    if (off_i) begin
                        state_d = SlotIdle;
                    end else if (snooze_i) begin
                        state_d  = SlotSnoozed;
                        snooze_d = SnoozeLoad;
                    end else if (timeout_i) begin
                        state_d = SlotIdle;
                    end
                end
                SlotSnoozed: begin
                    if (sec_tick_i) begin
                        snooze_d = snooze_q - SnoozeOne;
                        // Countdown reaches zero on this tick.
                        if (snooze_q == SnoozeOne) begin
                            state_d = SlotPending;
                        end
                    end
                end
                default: state_d = SlotIdle;
            endcase
        end
    end

    // Slot state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hour_q   <= '0;
            min_q    <= '0;
            en_q     <= 1'b0;
            state_q  <= SlotIdle;
            snooze_q <= '0;
        end else begin
            hour_q   <= hour_d;
            min_q    <= min_d;
            en_q     <= en_d;
            state_q  <= state_d;
            snooze_q <= snooze_d;
        end
    end

    assign hour_o       = hour_q;
    assign min_o        = min_q;
    assign enable_o     = en_q;
    assign state_o      = state_q;
    assign state_next_o = state_d;

endmodule

// File: rtl/alarm_bank.sv
// Multi-alarm engine: NUM_ALARMS slots, fixed-priority ring arbitration, ring timeout,
// snooze, and registered ring status for the buzzer.
module alarm_bank
    import clock_pkg::*;
#(
    parameter int unsigned NUM_ALARMS     = 4,
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter int unsigned RING_TIMEOUT_S = 60,
    localparam int unsigned IDX_W         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sec_tick,
    input  logic [HOUR_W-1:0]     hour_in,
    input  logic [MIN_W-1:0]      min_in,
    input  logic [SEC_W-1:0]      sec_in,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [HOUR_W-1:0]     wr_hour,
    input  logic [MIN_W-1:0]      wr_min,
    input  logic                  wr_enable,
    input  logic                  snooze_pulse,
    input  logic                  off_pulse,
    output logic [HOUR_W-1:0]     rd_hour,
    output logic [MIN_W-1:0]      rd_min,
    output logic [NUM_ALARMS-1:0] enabled_mask,
    output logic [NUM_ALARMS-1:0] snoozed_mask,
    output logic                  alarm_on,
    output logic [IDX_W-1:0]      ring_idx,
    output logic                  wr_err
);

    localparam logic [RING_CNT_W-1:0] RingLast = RING_CNT_W'(RING_TIMEOUT_S - 1);

    logic                  tick_q;
    logic                  match_tick;
    logic                  idx_ok;
    logic                  wr_ok;
    logic                  any_ringing;
    logic                  timeout;
    logic [NUM_ALARMS-1:0] pending;
    logic [NUM_ALARMS-1:0] ringing;
    logic [NUM_ALARMS-1:0] ringing_next;
    logic [NUM_ALARMS-1:0] grant;
    logic [RING_CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic                  alarm_on_q, alarm_on_d;
    logic [IDX_W-1:0]      ring_idx_q, ring_idx_d;
    logic                  wr_err_q, wr_err_d;

    logic [HOUR_W-1:0] slot_hour [NUM_ALARMS];
    logic [MIN_W-1:0]  slot_min [NUM_ALARMS];
    slot_state_e       slot_state [NUM_ALARMS];
    slot_state_e       slot_state_next [NUM_ALARMS];

    // sec_tick arrives with the counter update, so compare one cycle later.
    assign match_tick = tick_q && (sec_in == '0);
    assign idx_ok     = int'(wr_idx) < int'(NUM_ALARMS);
    assign wr_ok      = wr_en && idx_ok && valid_time(wr_hour, wr_min);
    assign wr_err_d   = wr_en && !wr_ok;

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
        alarm_slot #(
            .SnoozeMin(SNOOZE_MIN)
        ) u_slot (
            .clk_i       (clk),
            .rst_i       (rst),
            .sec_tick_i  (sec_tick),
            .match_tick_i(match_tick),
            .hour_i      (hour_in),
            .min_i       (min_in),
            .wr_i        (wr_ok && (wr_idx == IDX_W'(g))),
            .wr_hour_i   (wr_hour),
            .wr_min_i    (wr_min),
            .wr_enable_i (wr_enable),
            .grant_i     (grant[g]),
            .off_i       (off_pulse),
            .snooze_i    (snooze_pulse),
            .timeout_i   (timeout),
            .hour_o      (slot_hour[g]),
            .min_o       (slot_min[g]),
            .enable_o    (enabled_mask[g]),
            .state_o     (slot_state[g]),
            .state_next_o(slot_state_next[g])
        );
        assign pending[g]      = slot_state[g] == SlotPending;
        assign ringing[g]      = slot_state[g] == SlotRinging;
        assign ringing_next[g] = slot_state_next[g] == SlotRinging;
        assign snoozed_mask[g] = slot_state[g] == SlotSnoozed;
    end

    assign any_ringing = |ringing;
    assign timeout     = any_ringing && sec_tick && (ring_cnt_q == RingLast);

    // Fixed-priority arbiter: lowest pending slot rings once nothing else is ringing.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        if (!any_ringing) begin
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                if (pending[i] && !found) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    // Ring counter restarts on every grant and counts seconds of ringing.
    always_comb begin
        ring_cnt_d = ring_cnt_q;
        if (|grant) begin
            ring_cnt_d = '0;
        end else if (any_ringing && sec_tick) begin
            ring_cnt_d = ring_cnt_q + RING_CNT_W'(1);
        end
    end

    // Output status tracks the slot states as they will be after this edge.
    always_comb begin
        logic found;
        alarm_on_d = |ringing_next;
        ring_idx_d = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (ringing_next[i] && !found) begin
                ring_idx_d = IDX_W'(i);
                found      = 1'b1;
            end
        end
    end

    // Combinational read-back of the addressed slot.
    always_comb begin
        rd_hour = '0;
        rd_min  = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                rd_hour = slot_hour[i];
                rd_min  = slot_min[i];
            end
        end
    end

    // Top-level state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q     <= 1'b0;
            ring_cnt_q <= '0;
            alarm_on_q <= 1'b0;
            ring_idx_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            tick_q     <= sec_tick;
            ring_cnt_q <= ring_cnt_d;
            alarm_on_q <= alarm_on_d;
            ring_idx_q <= ring_idx_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign alarm_on = alarm_on_q;
    assign ring_idx = ring_idx_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: write-port vector table plus ring/snooze/timeout sequences.
module tb_alarm_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic [4:0] hour_in;
    logic [5:0] min_in;
    logic [5:0] sec_in;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [4:0] wr_hour;
    logic [5:0] wr_min;
    logic       wr_enable;
    logic       snooze_pulse;
    logic       off_pulse;
    logic [4:0] rd_hour;
    logic [5:0] rd_min;
    logic [3:0] enabled_mask;
    logic [3:0] snoozed_mask;
    logic       alarm_on;
    logic [1:0] ring_idx;
    logic       wr_err;

    int errors = 0;
    int checks = 0;

    alarm_bank #(
        .NUM_ALARMS    (4),
        .SNOOZE_MIN    (1),
        .RING_TIMEOUT_S(60)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sec_tick    (sec_tick),
        .hour_in     (hour_in),
        .min_in      (min_in),
        .sec_in      (sec_in),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_hour     (wr_hour),
        .wr_min      (wr_min),
        .wr_enable   (wr_enable),
        .snooze_pulse(snooze_pulse),
        .off_pulse   (off_pulse),
        .rd_hour     (rd_hour),
        .rd_min      (rd_min),
        .enabled_mask(enabled_mask),
        .snoozed_mask(snoozed_mask),
        .alarm_on    (alarm_on),
        .ring_idx    (ring_idx),
        .wr_err      (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] idx;
        logic [4:0] hour;
        logic [5:0] min;
        logic       en;
        logic       exp_err;
        logic [4:0] exp_hour;
        logic [5:0] exp_min;
        logic [3:0] exp_mask;
    } wr_vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle sec_tick; the clock value changes on the same edge, like time_counter.
    task automatic do_tick(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        sec_tick = 1'b1;
        @(posedge clk);
        #1;
        sec_tick = 1'b0;
        hour_in  = h;
        min_in   = m;
        sec_in   = s;
    endtask

    task automatic do_write(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m,
                            input logic en);
        wr_en     = 1'b1;
        wr_idx    = idx;
        wr_hour   = h;
        wr_min    = m;
        wr_enable = en;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_keys(input logic off, input logic snz);
        off_pulse    = off;
        snooze_pulse = snz;
        step(1);
        off_pulse    = 1'b0;
        snooze_pulse = 1'b0;
    endtask

    wr_vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd0, 5'd7,  6'd30, 1'b1, 1'b0, 5'd7,  6'd30, 4'b0001};
        vecs[1] = '{2'd1, 5'd8,  6'd0,  1'b1, 1'b0, 5'd8,  6'd0,  4'b0011};
        vecs[2] = '{2'd2, 5'd8,  6'd0,  1'b1, 1'b0, 5'd8,  6'd0,  4'b0111};
        vecs[3] = '{2'd1, 5'd24, 6'd0,  1'b0, 1'b1, 5'd8,  6'd0,  4'b0111};
        vecs[4] = '{2'd2, 5'd12, 6'd60, 1'b0, 1'b1, 5'd8,  6'd0,  4'b0111};
        vecs[5] = '{2'd3, 5'd23, 6'd59, 1'b0, 1'b0, 5'd23, 6'd59, 4'b0111};
        vecs[6] = '{2'd3, 5'd0,  6'd0,  1'b0, 1'b0, 5'd0,  6'd0,  4'b0111};

        rst = 1'b1; sec_tick = 1'b0; hour_in = '0; min_in = '0; sec_in = '0;
        wr_en = 1'b0; wr_idx = '0; wr_hour = '0; wr_min = '0; wr_enable = 1'b0;
        snooze_pulse = 1'b0; off_pulse = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);

        check("reset alarm_on", alarm_on, 0);
        check("reset ring_idx", ring_idx, 0);
        check("reset wr_err", wr_err, 0);
        check("reset enabled_mask", enabled_mask, 0);
        check("reset snoozed_mask", snoozed_mask, 0);
        check("reset rd_hour", rd_hour, 0);
        check("reset rd_min", rd_min, 0);

        // Write-port table: legal limits, out-of-range hour/minute rejected.
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].idx, vecs[i].hour, vecs[i].min, vecs[i].en);
            check($sformatf("vec%0d wr_err", i), wr_err, vecs[i].exp_err);
            check($sformatf("vec%0d rd_hour", i), rd_hour, vecs[i].exp_hour);
            check($sformatf("vec%0d rd_min", i), rd_min, vecs[i].exp_min);
            check($sformatf("vec%0d enabled_mask", i), enabled_mask, vecs[i].exp_mask);
        end
        step(1);
        check("wr_err is one pulse", wr_err, 0);

        // Slot 0 at 07:30 rings three clocks after the tick onto 07:30:00.
        hour_in = 5'd7; min_in = 6'd29; sec_in = 6'd58;
        do_tick(5'd7, 6'd29, 6'd59);
        step(3);
        check("no ring at 07:29:59", alarm_on, 0);
        do_tick(5'd7, 6'd30, 6'd0);
        check("match +1 alarm_on", alarm_on, 0);
        step(1);
        check("match +2 alarm_on", alarm_on, 0);
        step(1);
        check("match +3 alarm_on", alarm_on, 1);
        check("match +3 ring_idx", ring_idx, 0);

        pulse_keys(1'b1, 1'b0);
        check("off drops alarm_on", alarm_on, 0);
        check("off keeps enable", enabled_mask, 4'b0111);

        do_tick(5'd7, 6'd31, 6'd0);
        step(3);
        check("no ring at 07:31", alarm_on, 0);
        do_tick(5'd7, 6'd30, 6'd0);
        step(2);
        check("re-arm rings again", alarm_on, 1);

        // Snooze for one minute: returns after exactly 60 ticks.
        pulse_keys(1'b0, 1'b1);
        check("snooze drops alarm_on", alarm_on, 0);
        check("snooze mask", snoozed_mask, 4'b0001);
        for (int k = 1; k < 60; k++) do_tick(5'd10, 6'd0, 6'(k));
        step(3);
        check("59 ticks still snoozed", alarm_on, 0);
        check("59 ticks snoozed mask", snoozed_mask, 4'b0001);
        do_tick(5'd10, 6'd1, 6'd0);
        step(1);
        check("60th tick re-rings", alarm_on, 1);
        check("re-ring idx", ring_idx, 0);
        check("re-ring snoozed cleared", snoozed_mask, 0);
        step(2);

        // Auto-timeout after the 60th tick of ringing.
        for (int k = 1; k < 60; k++) do_tick(5'd11, 6'd0, 6'(k));
        step(1);
        check("59 ticks still ringing", alarm_on, 1);
        do_tick(5'd11, 6'd1, 6'd0);
        check("timeout drops alarm_on", alarm_on, 0);
        check("timeout not snoozed", snoozed_mask, 0);
        check("timeout keeps enable", enabled_mask, 4'b0111);

        // Slots 1 and 2 match together: index order.
        do_tick(5'd8, 6'd0, 6'd0);
        step(2);
        check("dual match alarm_on", alarm_on, 1);
        check("dual match ring_idx", ring_idx, 1);
        pulse_keys(1'b1, 1'b0);
        check("off slot1 alarm_on", alarm_on, 0);
        step(1);
        check("slot2 granted alarm_on", alarm_on, 1);
        check("slot2 granted ring_idx", ring_idx, 2);

        // Disabling write to the ringer cancels it.
        do_write(2'd2, 5'd8, 6'd0, 1'b0);
        check("write cancels ringer", alarm_on, 0);
        check("write cancels enable", enabled_mask, 4'b0011);
        step(2);
        check("cancel stays off", alarm_on, 0);

        // Off with nothing ringing is ignored.
        pulse_keys(1'b1, 1'b0);
        check("idle off alarm_on", alarm_on, 0);
        check("idle off enable", enabled_mask, 4'b0011);

        // Off and snooze together: off wins.
        do_tick(5'd8, 6'd0, 6'd0);
        step(2);
        check("slot1 rings again", alarm_on, 1);
        check("slot1 ring_idx", ring_idx, 1);
        pulse_keys(1'b1, 1'b1);
        check("off+snooze alarm_on", alarm_on, 0);
        check("off+snooze not snoozed", snoozed_mask, 0);

        // Reset while ringing clears everything.
        do_tick(5'd7, 6'd30, 6'd0);
        step(2);
        check("pre-reset ring", alarm_on, 1);
        wr_idx = 2'd0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("reset mid-ring alarm_on", alarm_on, 0);
        check("reset mid-ring enable", enabled_mask, 0);
        check("reset mid-ring rd_hour", rd_hour, 0);
        check("reset mid-ring rd_min", rd_min, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
